// File: rtl/xor_ram_bit_popper_pkg.sv
// Shared state encodings and address-width helper for the XOR-RAM pending-bit popper.
package xor_ram_bit_popper_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_SCAN  = 2'd0;
    localparam state_t ST_HOLD  = 2'd1;
    localparam state_t ST_CLEAR = 2'd2;
    localparam state_t ST_FLUSH = 2'd3;

    // Number of bits needed to represent 'value' (at least 1).
    function automatic int log2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) <= value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/xor_ram_bit_popper.sv
// Consumer side of a toggle-based 1-bit bitmap RAM: scans round-robin, pops set
// addresses over valid/ready, clears them by toggling, and supports a full flush sweep.
module xor_ram_bit_popper
    import xor_ram_bit_popper_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = log2(DEPTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    input  logic                  ram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ZERO_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic                  r_out_valid;
    logic                  r_flush_pending;
    logic                  r_flush_done;
    logic [ADDR_WIDTH:0]   r_zero_cnt;

    // DEPTH need not be a power of two, so wrap explicitly at the last entry.
    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_SCAN;
            r_ptr           <= '0;
            r_out_addr      <= '0;
            r_out_valid     <= 1'b0;
            r_flush_pending <= 1'b0;
            r_flush_done    <= 1'b0;
            r_zero_cnt      <= '0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (ram_q) begin
                        r_zero_cnt <= '0;
                    end else if (r_zero_cnt != ZERO_FULL) begin
                        r_zero_cnt <= r_zero_cnt + (ADDR_WIDTH + 1)'(1);
                    end
                    if (r_flush_pending || flush_req) begin
                        r_state         <= ST_FLUSH;
                        r_ptr           <= '0;
                        r_flush_pending <= 1'b0;
                    end else if (ram_q) begin
                        r_out_addr  <= r_ptr;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_ptr <= wrap_inc(r_ptr);
                    end
                end
                ST_HOLD: begin
                    if (flush_req) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // Resume past the popped entry so lower addresses cannot starve higher ones.
                    if (flush_req) begin
                        r_flush_pending <= 1'b1;
                    end
                    r_ptr   <= wrap_inc(r_out_addr);
                    r_state <= ST_SCAN;
                end
                ST_FLUSH: begin
                    if (r_ptr == LAST_ADDR) begin
                        r_ptr        <= '0;
                        r_flush_done <= 1'b1;
                        r_zero_cnt   <= ZERO_FULL;
                        r_state      <= ST_SCAN;
                    end else begin
                        r_ptr <= wrap_inc(r_ptr);
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    always_comb begin
        ram_addr = r_ptr;
        ram_wr   = 1'b0;
        case (r_state)
            ST_HOLD: begin
                ram_addr = r_out_addr;
            end
            ST_CLEAR: begin
                ram_addr = r_out_addr;
                ram_wr   = 1'b1;
            end
            ST_FLUSH: begin
                // Toggling only set bits turns every visited entry into a zero.
                ram_wr = ram_q;
            end
            default: begin
                ram_wr = 1'b0;
            end
        endcase
    end

    assign out_valid  = r_out_valid;
    assign out_addr   = r_out_addr;
    assign flush_done = r_flush_done;
    assign empty      = (r_zero_cnt == ZERO_FULL);

endmodule
